// File: rtl/input_keypad_scanner.sv
// Scanner for a 4x4 active-low key matrix with a 2-flop column synchronizer and per-frame debounce.
// Frames with more than one key down are rejected; each press is delivered once through a one-entry valid/ready slot.
module input_keypad_scanner #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   output logic [0:3] KR,
   input  logic [0:3] KC,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_down,
   output logic       overrun
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

   function automatic logic [4:0] pop16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   function automatic logic [3:0] idx16(input logic [15:0] v);
      logic [3:0] k;
      k = '0;
      for (int i = 0; i < 16; i++) if (v[i]) k = 4'(i);
      return k;
   endfunction

   logic [0:3]    kc_meta, kc_sync;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    row_idx;
   logic [15:0]   snap;
   logic [15:0]   frame;
   logic          sample, frame_done;
   logic          frame_none, frame_single;
   logic [3:0]    frame_code;
   state_t        state, state_nx;
   logic [3:0]    cand, cand_nx, cnt, cnt_nx;
   logic          qualify, accept;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         kc_meta <= 4'b1111;
         kc_sync <= 4'b1111;
      end else begin
         kc_meta <= KC;
         kc_sync <= kc_meta;
      end
   end

   assign sample     = (slot_cnt == SLOT_LAST);
   assign frame_done = sample && (row_idx == 2'd3);

   always_comb begin
      KR          = 4'b1111;
      KR[row_idx] = 1'b0;
   end

   // snapshot bit row*4+col is set when that key was seen down
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         slot_cnt <= '0;
         row_idx  <= '0;
         snap     <= '0;
      end else if (sample) begin
         slot_cnt <= '0;
         row_idx  <= row_idx + 2'd1;
         for (int c = 0; c < 4; c++) snap[{row_idx, 2'(c)}] <= ~kc_sync[c];
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   // row 3 is classified straight from the synchronizer on the cycle it is sampled
   always_comb begin
      frame = snap;
      for (int c = 0; c < 4; c++) frame[12 + c] = ~kc_sync[c];
   end

   assign frame_none   = (pop16(frame) == 5'd0);
   assign frame_single = (pop16(frame) == 5'd1);
   assign frame_code   = idx16(frame);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cand  <= cand_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      qualify  = 1'b0;
      if (frame_done) begin
         case (state)
            IDLE: begin
               if (frame_single) begin
                  cand_nx = frame_code;
                  cnt_nx  = 4'd1;
                  if (DEBOUNCE == 1) begin
                     qualify  = 1'b1;
                     state_nx = PRESSED;
                  end else begin
                     state_nx = PRESS_CHK;
                  end
               end
            end
            PRESS_CHK: begin
               if (frame_single && (frame_code == cand)) begin
                  cnt_nx = cnt + 4'd1;
                  if ((cnt + 4'd1) == DB_LAST) begin
                     qualify  = 1'b1;
                     state_nx = PRESSED;
                  end
               end else begin
                  state_nx = IDLE;
               end
            end
            PRESSED: begin
               if (frame_none) begin
                  cnt_nx   = 4'd1;
                  state_nx = (DEBOUNCE == 1) ? IDLE : RELEASE_CHK;
               end
            end
            RELEASE_CHK: begin
               if (frame_none) begin
                  cnt_nx = cnt + 4'd1;
                  if ((cnt + 4'd1) == DB_LAST) state_nx = IDLE;
               end else begin
                  state_nx = PRESSED;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign key_down = (state == PRESSED) || (state == RELEASE_CHK);
   assign accept   = key_valid && key_ready;

   // a qualify that finds the slot occupied and not draining is dropped; drop beats clear
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (qualify && (!key_valid || accept)) begin
            key_code  <= frame_code;
            key_valid <= 1'b1;
         end else if (accept) begin
            key_valid <= 1'b0;
         end
         if (qualify && key_valid && !accept) overrun <= 1'b1;
         else if (accept)                     overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_keypad_scanner.sv
// Directed bench for input_keypad_scanner: a key-matrix model drives the columns, and accepted keys are checked against a queue of expected codes.
module tb_input_keypad_scanner;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [0:3]  kr, kc;
   logic [3:0]  key_code;
   logic        key_valid, key_ready, key_down, overrun;
   logic [15:0] pressed;
   logic        kc_force_low;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [3:0]  exp_q[$];

   always #5 Clock = ~Clock;

   // column c reads low when a held key on the currently driven row shares it
   always_comb begin
      kc = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kr[r] && pressed[r*4+c]) kc[c] = 1'b0;
      if (kc_force_low) kc = 4'b0000;
   end

   input_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .KR        (kr),
      .KC        (kc),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_down  (key_down),
      .overrun   (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // each cycle: score a handshake about to happen on the next posedge, then advance
   task automatic tick(input int n);
      repeat (n) begin
         if (Reset && key_valid && key_ready) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL spurious_key observed code=%0d expected no key", key_code);
            end
            if (exp_q.size() > 0) chk("key_code", {28'b0, key_code}, {28'b0, exp_q.pop_front()});
         end
         @(negedge Clock);
      end
   endtask

   task automatic wait_keys(input string tag, input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   task automatic bounce9();
      repeat (10) begin
         pressed[9] = ~pressed[9];
         tick(10);
      end
   endtask

   initial begin
      logic [0:3] exp_kr;
      int k;
      Reset        = 1'b0;
      pressed      = '0;
      key_ready    = 1'b0;
      kc_force_low = 1'b1;
      tick(3);
      chk("reset_kr",        {28'b0, kr}, 32'h7);
      chk("reset_key_valid", {31'b0, key_valid}, 0);
      chk("reset_overrun",   {31'b0, overrun}, 0);
      chk("reset_key_down",  {31'b0, key_down}, 0);
      chk("reset_key_code",  {28'b0, key_code}, 0);
      kc_force_low = 1'b0;
      tick(2);
      Reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         exp_kr = ~(4'b1000 >> (((i + 1) >> 2) & 3));
         chk("kr_walk", {28'b0, kr}, {28'b0, exp_kr});
      end

      // clean press of row2/col1
      key_ready  = 1'b1;
      pressed[9] = 1'b1;
      exp_q.push_back(4'd9);
      wait_keys("clean_latency", 67);
      tick(60);
      chk("clean_key_down",   {31'b0, key_down}, 1);
      chk("clean_valid_once", {31'b0, key_valid}, 0);
      pressed[9] = 1'b0;
      tick(20);
      chk("release_key_down_hold", {31'b0, key_down}, 1);
      tick(52);
      chk("release_key_down", {31'b0, key_down}, 0);

      // bounce on press, then hold
      exp_q.push_back(4'd9);
      bounce9();
      pressed[9] = 1'b1;
      wait_keys("bounce_press", 100);
      tick(40);
      chk("bounce_held_down", {31'b0, key_down}, 1);
      // bounce on release
      bounce9();
      pressed[9] = 1'b0;
      tick(100);
      chk("bounce_release_down", {31'b0, key_down}, 0);

      // two keys together from IDLE
      pressed[0] = 1'b1;
      pressed[6] = 1'b1;
      tick(100);
      chk("ghost_no_valid", {31'b0, key_valid}, 0);
      chk("ghost_no_down",  {31'b0, key_down}, 0);
      pressed = '0;
      tick(80);
      pressed[0] = 1'b1;
      exp_q.push_back(4'd0);
      wait_keys("single_key0", 67);
      pressed[15] = 1'b1;
      tick(80);
      chk("second_key_down", {31'b0, key_down}, 1);
      chk("second_no_valid", {31'b0, key_valid}, 0);
      pressed = '0;
      tick(80);

      // backpressure: second key must be dropped with overrun
      key_ready  = 1'b0;
      pressed[5] = 1'b1;
      exp_q.push_back(4'd5);
      k = 0;
      while (!key_valid && k < 80) begin
         tick(1);
         k++;
      end
      chk("bp_first_valid", {31'b0, key_valid}, 1);
      pressed[5] = 1'b0;
      tick(80);
      pressed[12] = 1'b1;
      tick(80);
      chk("bp_valid",   {31'b0, key_valid}, 1);
      chk("bp_code",    {28'b0, key_code}, 5);
      chk("bp_overrun", {31'b0, overrun}, 1);
      chk("bp_pending", exp_q.size(), 1);
      pressed[12] = 1'b0;
      tick(80);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      chk("bp_drain_valid",   {31'b0, key_valid}, 0);
      chk("bp_drain_overrun", {31'b0, overrun}, 0);
      chk("bp_drained",       exp_q.size(), 0);

      // asynchronous reset while debouncing a press
      key_ready  = 1'b1;
      pressed[9] = 1'b1;
      tick(26);
      #2 Reset = 1'b0;
      #1;
      chk("mid_reset_kr",       {28'b0, kr}, 32'h7);
      chk("mid_reset_valid",    {31'b0, key_valid}, 0);
      chk("mid_reset_down",     {31'b0, key_down}, 0);
      chk("mid_reset_overrun",  {31'b0, overrun}, 0);
      chk("mid_reset_key_code", {28'b0, key_code}, 0);
      tick(3);
      Reset = 1'b1;
      exp_q.push_back(4'd9);
      tick(40);
      chk("fresh_debounce_wait", {31'b0, key_valid}, 0);
      chk("fresh_debounce_pend", exp_q.size(), 1);
      wait_keys("fresh_debounce_key", 40);
      pressed = '0;
      tick(80);
      chk("final_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
